// File: rtl/rsa_host_if.sv
// rsa_host_if: host-side sequencer for a word-serial 256-bit RSA core.
// It latches msg/exp/mod on start and streams 24 operand words to the core.
// It then waits for the core's output-valid flag and gathers 8 result words.
// After that it raises done and holds busy through a fixed idle gap.
// Optional build macro: RSA_HOST_TIMEOUT_EN adds a WAIT-state timeout abort
// that reports through err. When it is undefined, err is tied low.
module rsa_host_if #(
   parameter int TIMEOUT_CYCLES = 1048576,
   parameter int IDLE_GAP       = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [255:0] msg,
   input  logic [255:0] exp,
   input  logic [255:0] mod,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [255:0] result,
   output logic         rsa_enable,
   output logic [31:0]  rsa_data,
   input  logic [31:0]  rsa_out,
   input  logic         rsa_flag
);

   typedef enum logic [2:0] {
      IDLE, SETUP, LOAD, WAIT, CAPTURE, DONE, GAP
   } state_t;

   // One shared counter covers LOAD words, CAPTURE words and the idle gap.
   localparam int CNT_MAX = (IDLE_GAP > 24) ? IDLE_GAP : 24;
   localparam int CW      = $clog2(CNT_MAX + 1);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [767:0]    opnd;   // {msg, exp, mod}, shifted out MSB word first
   logic [223:0]    cap;    // first seven result words, oldest in the MSBs

   // A zero or negative timeout can never fire; reject it at elaboration.
   if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
      $error("rsa_host_if: TIMEOUT_CYCLES must be at least 1");
   end

`ifdef RSA_HOST_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt;
   logic          err_r;
   assign err = err_r;
`else
   assign err = 1'b0;
`endif

   // Main sequencer: state, counters and all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         rsa_enable <= 1'b0;
         rsa_data   <= '0;
         result     <= '0;
         cnt        <= '0;
`ifdef RSA_HOST_TIMEOUT_EN
         tcnt       <= '0;
         err_r      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  opnd       <= {msg, exp, mod};
                  busy       <= 1'b1;
                  rsa_enable <= 1'b1;
                  rsa_data   <= '0;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               rsa_data <= opnd[767:736];
               opnd     <= {opnd[735:0], 32'b0};
               cnt      <= '0;
               state    <= LOAD;
            end
            LOAD: begin
               // The last word (mod[31:0]) stays on rsa_data throughout WAIT.
               if (cnt == CW'(23)) begin
                  cnt   <= '0;
                  state <= WAIT;
`ifdef RSA_HOST_TIMEOUT_EN
                  tcnt  <= '0;
`endif
               end else begin
                  rsa_data <= opnd[767:736];
                  opnd     <= {opnd[735:0], 32'b0};
                  cnt      <= cnt + 1'b1;
               end
            end
            WAIT: begin
               if (rsa_flag) begin
                  cap   <= {cap[191:0], rsa_out};
                  cnt   <= '0;
                  state <= CAPTURE;
               end
`ifdef RSA_HOST_TIMEOUT_EN
               else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  done       <= 1'b1;
                  err_r      <= 1'b1;
                  rsa_enable <= 1'b0;
                  rsa_data   <= '0;
                  cnt        <= '0;
                  state      <= DONE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
`endif
            end
            CAPTURE: begin
               // result changes only here, so it stays stable between done pulses.
               if (cnt == CW'(6)) begin
                  result     <= {cap, rsa_out};
                  done       <= 1'b1;
`ifdef RSA_HOST_TIMEOUT_EN
                  err_r      <= 1'b0;
`endif
                  rsa_enable <= 1'b0;
                  rsa_data   <= '0;
                  cnt        <= '0;
                  state      <= DONE;
               end else begin
                  cap <= {cap[191:0], rsa_out};
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               // The DONE cycle counts as the first cycle of the idle gap.
               if (IDLE_GAP <= 1) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt   <= CW'(1);
                  state <= GAP;
               end
            end
            GAP: begin
               if (cnt >= CW'(IDLE_GAP - 1)) begin
                  busy  <= 1'b0;
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_host_if.sv
// tb_rsa_host_if: scoreboard bench for rsa_host_if (default build).
// A behavioural core model checks the operand word stream and answers with
// either fixed words 1..8 or a real modular exponentiation. A done monitor
// pops the expected result and checks the gap length that follows.
module tb_rsa_host_if;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [255:0] msg = '0, exp = '0, mod = '0;
   logic         busy, done, err, rsa_enable;
   logic [255:0] result;
   logic [31:0]  rsa_data;
   logic [31:0]  rsa_out = '0;
   logic         rsa_flag = 1'b0;

   rsa_host_if #(.TIMEOUT_CYCLES(1048576), .IDLE_GAP(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .msg(msg), .exp(exp), .mod(mod),
      .busy(busy), .done(done), .err(err), .result(result),
      .rsa_enable(rsa_enable), .rsa_data(rsa_data),
      .rsa_out(rsa_out), .rsa_flag(rsa_flag)
   );

   always #5 clk = ~clk;

   localparam logic [255:0] MSG_TXT = "RSA-256 passed congragulations:)";
   // 2^255 - 19 is prime, so exponent pairs with e*d = 1 mod (N-1) round-trip.
   localparam logic [255:0] N_KEY =
      256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
   localparam logic [255:0] FIXED_RES =
      256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;

   typedef struct {
      logic [255:0] res;
      logic         err;
   } exp_t;

   int           checks = 0;
   int           errors = 0;
   exp_t         res_q[$];
   logic [31:0]  word_q[$];

   // core model state
   int           core_e = 0;
   int           core_mode = 0;
   int           core_delay = 1;
   int           en_count = 0;
   logic [31:0]  core_words[24];
   logic [31:0]  resp[8];

   // done-monitor state
   logic         in_gap = 1'b0;
   int           gap_cnt = 0;

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   function automatic logic [255:0] modexp(input logic [255:0] b, input logic [255:0] x,
                                           input logic [255:0] n);
      logic [511:0] r, s, nn;
      nn = {256'b0, n};
      r  = 512'd1;
      s  = {256'b0, b} % nn;
      for (int i = 0; i < 256; i++) begin
         if (x[i]) r = (r * s) % nn;
         s = (s * s) % nn;
      end
      return r[255:0];
   endfunction

   // Modular inverse by extended Euclid; 0 when a is not invertible mod m.
   function automatic logic [255:0] modinv(input logic [255:0] a, input logic [255:0] m);
      logic [511:0] r0, r1, t0, t1, q, tmp, mm;
      mm = {256'b0, m};
      r0 = mm;
      r1 = {256'b0, a};
      t0 = '0;
      t1 = 512'd1;
      while (r1 != 0) begin
         q   = r0 / r1;
         tmp = r0 - q * r1;
         r0  = r1;
         r1  = tmp;
         tmp = (t0 + mm - ((q * t1) % mm)) % mm;
         t0  = t1;
         t1  = tmp;
      end
      return (r0 == 512'd1) ? t0[255:0] : 256'd0;
   endfunction

   // Behavioural RSA core: checks each operand word against the scoreboard,
   // then answers core_delay WAIT cycles later with 8 result words.
   always @(negedge clk) begin
      if (rsa_enable) begin
         if (core_e == 0) begin
            check("setup_word", {224'b0, rsa_data}, 256'd0);
         end else if (core_e <= 24) begin
            core_words[core_e-1] = rsa_data;
            if (word_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %h expected none", rsa_data);
            end else begin
               check($sformatf("word_%0d", core_e - 1), {224'b0, rsa_data},
                     {224'b0, word_q.pop_front()});
            end
            if (core_e == 24) begin
               logic [255:0] m, x, n, r;
               for (int i = 0; i < 8; i++) begin
                  m[255-32*i -: 32] = core_words[i];
                  x[255-32*i -: 32] = core_words[8+i];
                  n[255-32*i -: 32] = core_words[16+i];
               end
               r = (core_mode == 1) ? modexp(m, x, n) : FIXED_RES;
               for (int i = 0; i < 8; i++) resp[i] = r[255-32*i -: 32];
            end
         end
         if (core_e >= 24 + core_delay && core_e < 32 + core_delay) begin
            rsa_flag = 1'b1;
            rsa_out  = resp[core_e-24-core_delay];
         end
         core_e++;
         en_count = core_e;
      end else begin
         core_e   = 0;
         rsa_flag = 1'b0;
         rsa_out  = '0;
      end
   end

   // Done monitor: compares each done against the scoreboard and measures the gap.
   always @(negedge clk) begin
      if (done) begin
         $display("done: result=%h err=%b", result, err);
         if (res_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got result %h expected no done", result);
         end else begin
            exp_t e;
            e = res_q.pop_front();
            check("result", result, e.res);
            check("err", {255'b0, err}, {255'b0, e.err});
         end
         in_gap  = 1'b1;
         gap_cnt = 0;
      end
      if (in_gap) begin
         if (!busy) begin
            check("gap_len", 256'(gap_cnt), 256'd4);
            in_gap = 1'b0;
         end else if (!rsa_enable) begin
            gap_cnt++;
         end
      end
   end

   // Call at a negedge; returns at the negedge of the SETUP cycle.
   task automatic issue(input logic [255:0] m, input logic [255:0] x, input logic [255:0] n,
                        input logic [255:0] eres, input int mode, input int dly);
      logic [767:0] ops;
      exp_t e;
      ops        = {m, x, n};
      core_mode  = mode;
      core_delay = dly;
      for (int k = 0; k < 24; k++) word_q.push_back(ops[767-32*k -: 32]);
      e.res = eres;
      e.err = 1'b0;
      res_q.push_back(e);
      msg   = m;
      exp   = x;
      mod   = n;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 256'(busy), 256'd1);
   endtask

   task automatic wait_idle(input int limit);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL idle_timeout: got busy=1 after %0d cycles expected busy=0", limit);
      end
      check("pending_results", 256'(res_q.size()), 256'd0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"}, 256'(busy), 256'd0);
      check({tag, "_done"}, 256'(done), 256'd0);
      check({tag, "_err"}, 256'(err), 256'd0);
      check({tag, "_enable"}, 256'(rsa_enable), 256'd0);
      check({tag, "_data"}, {224'b0, rsa_data}, 256'd0);
      check({tag, "_result"}, result, 256'd0);
   endtask

   task automatic apply_reset(input string tag);
      rst_n = 1'b0;
      @(negedge clk);
      check_zero_outputs(tag);
      rst_n = 1'b1;
      word_q.delete();
      res_q.delete();
   endtask

   initial begin
      logic [767:0] ops;
      logic [255:0] m0, x0, n0, e_pub, d_priv, ct;
      int cands[5] = '{65537, 17, 257, 5, 7};
      bit found;

      for (int k = 0; k < 24; k++) ops[767-32*k -: 32] = 32'hc0de0000 + 32'(k);
      m0 = ops[767:512];
      x0 = ops[511:256];
      n0 = ops[255:0];

      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Fixed response words, flag after 1 and after 500 WAIT cycles.
      issue(m0, x0, n0, FIXED_RES, 0, 1);
      wait_idle(200);
      check("enable_cycles_d1", 256'(en_count), 256'd33);
      issue(m0, x0, n0, FIXED_RES, 0, 500);
      wait_idle(700);
      check("enable_cycles_d500", 256'(en_count), 256'd532);

      // Reset while LOAD word 10 is on the bus, then a clean run.
      issue(m0, x0, n0, FIXED_RES, 0, 3);
      repeat (11) @(negedge clk);
      apply_reset("midload");
      issue(m0, x0, n0, FIXED_RES, 0, 3);
      wait_idle(200);
      check("enable_cycles_d3", 256'(en_count), 256'd35);

      // Encrypt the ASCII message, then decrypt the DUT's ciphertext.
      found  = 1'b0;
      e_pub  = '0;
      d_priv = '0;
      foreach (cands[i]) begin
         if (!found) begin
            d_priv = modinv(256'(cands[i]), N_KEY - 256'd1);
            if (d_priv != 0) begin
               e_pub = 256'(cands[i]);
               found = 1'b1;
            end
         end
      end
      ct = modexp(MSG_TXT, e_pub, N_KEY);
      issue(MSG_TXT, e_pub, N_KEY, ct, 1, 4);
      wait_idle(300);
      issue(result, d_priv, N_KEY, MSG_TXT, 1, 2);
      wait_idle(300);

      // start during LOAD and on the DONE cycle is ignored; a start on the
      // first cycle with busy low is taken.
      issue(m0, x0, n0, FIXED_RES, 0, 2);
      repeat (5) @(negedge clk);
      msg   = MSG_TXT;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 100; i++) begin
            if (done) begin
               seen = 1'b1;
               break;
            end
            @(negedge clk);
         end
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
         end
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(20);
      issue(m0, x0, n0, FIXED_RES, 0, 1);
      wait_idle(200);
      check("enable_cycles_after_gap", 256'(en_count), 256'd33);

      // Core never raises its flag: without the timeout the host keeps waiting.
      issue(m0, x0, n0, FIXED_RES, 0, 100000);
      repeat (300) @(negedge clk);
      check("noflag_busy", 256'(busy), 256'd1);
      check("noflag_pending", 256'(res_q.size()), 256'd1);
      apply_reset("noflag_reset");
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish before 300000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/rsa_host_if.md
RSA_HOST_IF -- requirements
Module: rsa_host_if

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1048576: maximum WAIT-state cycles before abort; used only when RSA_HOST_TIMEOUT_EN is defined.
REQ-002 Parameter IDLE_GAP, default 4: minimum cycles with rsa_enable low between two operations.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to run one modular exponentiation.
REQ-006 msg  input  256  message/ciphertext operand; sampled on accepted start.
REQ-007 exp  input  256  exponent (e or d); sampled on accepted start.
REQ-008 mod  input  256  modulus N; sampled on accepted start.
REQ-009 busy  output  1  high from accepted start until the end of the idle gap.
REQ-010 done  output  1  one-cycle pulse when result is valid or the operation aborted.
REQ-011 err  output  1  valid with done; 1 = timeout abort.
REQ-012 result  output  256  captured core output, first word in [255:224]; held until the next done.
REQ-013 rsa_enable  output  1  operation-active strobe to the RSA core.
REQ-014 rsa_data  output  32  operand word stream to the RSA core.
REQ-015 rsa_out  input  32  result word stream from the RSA core.
REQ-016 rsa_flag  input  1  core output-valid flag; high from the first result word onward.

Function
REQ-017 FSM states: IDLE, SETUP, LOAD, WAIT, CAPTURE, DONE, GAP.
REQ-018 IDLE: start=1 latches msg/exp/mod, sets busy, and goes to SETUP; start is ignored in every other state.
REQ-019 SETUP: exactly one cycle, rsa_enable=1, rsa_data=0.
REQ-020 LOAD: 24 cycles, rsa_enable=1, word k (0..23) on rsa_data in LOAD cycle k; order msg[255:224]..msg[31:0], exp[255:224]..exp[31:0], mod[255:224]..mod[31:0].
REQ-021 WAIT: rsa_enable=1, rsa_data holds mod[31:0]; first edge with rsa_flag=1 captures rsa_out into result[255:224] and enters CAPTURE.
REQ-022 CAPTURE: the next 7 edges capture rsa_out into result[223:192] down to result[31:0], regardless of rsa_flag, then go to DONE.
REQ-023 DONE: one cycle, done=1, err=0, rsa_enable=0, then GAP.
REQ-024 GAP: IDLE_GAP cycles counted from DONE inclusive, rsa_enable=0, busy=1; then IDLE with busy=0.
REQ-025 rsa_flag in IDLE, SETUP, LOAD, DONE, GAP is ignored.
REQ-026 start in the same cycle busy falls is ignored; start is accepted on the first IDLE cycle with busy=0.
REQ-027 Latency from accepted start to the first rsa_flag sample: 26 cycles minimum (1 SETUP + 24 LOAD + 1 WAIT).

Reset
REQ-028 rst_n=0 at a clock edge forces IDLE, busy=0, done=0, err=0, rsa_enable=0, rsa_data=0, result=0, and clears all counters.
REQ-029 Reset mid-operation aborts with no done pulse; the first post-reset start is accepted normally.

Configuration
REQ-030 Macro RSA_HOST_TIMEOUT_EN defined: a WAIT-cycle counter runs, and reaching TIMEOUT_CYCLES without rsa_flag goes to DONE with done=1, err=1, rsa_enable=0, and result unchanged.
REQ-031 Macro RSA_HOST_TIMEOUT_EN undefined: no counter is built, err is tied 0, and WAIT persists until rsa_flag.

Verification
REQ-032 Reset during LOAD word 10 -> all outputs 0 next cycle; a subsequent start completes normally.
REQ-033 start with msg="RSA-256 passed congragulations:)", exp=e, N from the key file, behavioural core model -> 24 words in order, result = msg^e mod N, done pulse with err=0.
REQ-034 Feed the REQ-033 result back with exp=d -> result equals the original ASCII message.
REQ-035 start pulsed while busy, including on the DONE cycle -> ignored; rsa_enable stays low for exactly 4 cycles in GAP.
REQ-036 rsa_flag asserted 1 cycle vs 500 cycles into WAIT with rsa_out words 0x00000001..0x00000008 -> result = 0x00000001_00000002_..._00000008 in both cases.
REQ-037 With RSA_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16, rsa_flag never asserted -> done=1, err=1 on WAIT cycle 16; without the macro -> busy stays 1 indefinitely.
